// File: rtl/fp_add_arbiter_pkg.sv
// Shared types for the fp_add arbiter: FP add argument bundle, op ids,
// the registered request record and the grant encoding.
package fp_add_arbiter_pkg;

   typedef struct packed {
      int unsigned fp_width;
      int unsigned id_width;
   } cpu_config_t;

   localparam cpu_config_t EXAMPLE_CONFIG = '{fp_width: 32, id_width: 4};

   localparam int FP_WIDTH   = int'(EXAMPLE_CONFIG.fp_width);
   localparam int ID_WIDTH   = int'(EXAMPLE_CONFIG.id_width);
   localparam int EXPO_WIDTH = 8;

   typedef logic [ID_WIDTH-1:0] id_t;

   // Pre-decoded operands; expo_diff/swap are computed upstream and only routed here
   typedef struct packed {
      logic [FP_WIDTH-1:0]   rs1;
      logic [FP_WIDTH-1:0]   rs2;
      logic [EXPO_WIDTH:0]   expo_diff;
      logic                  swap;
      logic                  subtract;
      logic [2:0]            rm;
   } fp_add_inputs_t;

   typedef struct packed {
      id_t            id;
      fp_add_inputs_t args;
      logic           fma;
   } fp_add_arb_req_t;

   typedef enum logic [1:0] {
      GRANT_NONE,
      GRANT_ISSUE,
      GRANT_FMA
   } grant_t;

endpackage

// File: rtl/fp_add_arbiter_if.sv
// Bundles the issue, FMA-continuation and fp_add request channels of the arbiter.
// The arbiter uses the slave modport; the surrounding pipeline uses master.
interface fp_add_arbiter_if;
   import fp_add_arbiter_pkg::*;

   logic           issue_possible;
   logic           issue_new_request;
   id_t            issue_id;
   fp_add_inputs_t issue_args;
   logic           issue_ready;

   logic           fma_valid;
   id_t            fma_id;
   fp_add_inputs_t fma_args;
   logic           fma_ready;

   logic           out_valid;
   id_t            out_id;
   fp_add_inputs_t out_args;
   logic           out_fma;
   logic           out_ready;

   modport slave (
      input  issue_possible, issue_new_request, issue_id, issue_args,
      output issue_ready,
      input  fma_valid, fma_id, fma_args,
      output fma_ready,
      output out_valid, out_id, out_args, out_fma,
      input  out_ready
   );

   modport master (
      output issue_possible, issue_new_request, issue_id, issue_args,
      input  issue_ready,
      output fma_valid, fma_id, fma_args,
      input  fma_ready,
      input  out_valid, out_id, out_args, out_fma,
      output out_ready
   );

endinterface

// File: rtl/fp_add_arbiter.sv
// Shares one fp_add datapath between issued add/sub ops and FMA continuations.
// FMA wins by default; a starvation counter hands priority to issue after STARVE_LIMIT FMA grants.
module fp_add_arbiter
   import fp_add_arbiter_pkg::*;
#(
   parameter cpu_config_t CONFIG       = EXAMPLE_CONFIG,
   parameter int          STARVE_LIMIT = 4
)(
   input logic             clk,
   input logic             rst,
   fp_add_arbiter_if.slave bus
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   if (int'(CONFIG.fp_width) != FP_WIDTH || int'(CONFIG.id_width) != ID_WIDTH) begin : g_bad_config
      $error("fp_add_arbiter: CONFIG widths do not match the package types");
   end
   if (STARVE_LIMIT < 1) begin : g_bad_limit
      $error("fp_add_arbiter: STARVE_LIMIT must be at least 1");
   end

   logic            out_valid_r;
   fp_add_arb_req_t out_req;
   fp_add_arb_req_t next_req;
   logic [CNT_W-1:0] starve_cnt;

   logic   advance;
   logic   override;
   logic   issue_ready_c;
   logic   fma_ready_c;
   grant_t grant;

   // Readies never look at issue_new_request except fma_ready, which only yields to an actual issue
   always_comb begin
      advance       = ~out_valid_r | bus.out_ready;
      override      = (starve_cnt == LIMIT);
      issue_ready_c = advance & (~bus.fma_valid | override);
      fma_ready_c   = advance & ~(override & bus.issue_new_request);
      grant         = GRANT_NONE;
      next_req      = out_req;
      if (bus.issue_new_request) begin
         grant         = GRANT_ISSUE;
         next_req.id   = bus.issue_id;
         next_req.args = bus.issue_args;
         next_req.fma  = 1'b0;
      end else if (bus.fma_valid && fma_ready_c) begin
         grant         = GRANT_FMA;
         next_req.id   = bus.fma_id;
         next_req.args = bus.fma_args;
         next_req.fma  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_req     <= '0;
      end else if (advance) begin
         out_valid_r <= (grant != GRANT_NONE);
         out_req     <= next_req;
      end
   end

   // Clearing wins over counting; the count saturates so override persists until issue gets in
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (grant == GRANT_ISSUE || !bus.issue_possible) begin
         starve_cnt <= '0;
      end else if (grant == GRANT_FMA && !override) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   assign bus.issue_ready = issue_ready_c;
   assign bus.fma_ready   = fma_ready_c;
   assign bus.out_valid   = out_valid_r;
   assign bus.out_id      = out_req.id;
   assign bus.out_args    = out_req.args;
   assign bus.out_fma     = out_req.fma;

   a_issue_only_when_ready: assert property (
      @(posedge clk) disable iff (rst) bus.issue_new_request |-> issue_ready_c);

   a_hold_stable: assert property (
      @(posedge clk) disable iff (rst)
      (out_valid_r && !bus.out_ready) |=> (out_valid_r && $stable(out_req)));

endmodule
